// File: rtl/mul_iter.sv
// mul_iter: iterative multi-cycle multiplier serving MULT/MULTU (and MADD/MSUB partial
// products) for the EX stage. EX holds start_i high and stalls until ready_o rises, then
// consumes result_o and drops start_i; the unit returns to FREE on the following edge.
//
// Signed operands are converted to magnitudes up front, multiplied as unsigned with STEP
// multiplier bits retired per cycle, and the product sign is applied when the last step
// lands. A zero operand skips the iteration entirely.
//
// Ports
//   clk           in   1         clock, rising edge
//   rst           in   1         synchronous reset, active-high
//   signed_mul_i  in   1         1: two's-complement operands, 0: unsigned
//   opdata1_i     in   DATA_W    multiplicand
//   opdata2_i     in   DATA_W    multiplier
//   start_i       in   1         request, held high until the result is consumed
//   annul_i       in   1         abort the current operation
//   result_o      out  2*DATA_W  product {hi,lo}, valid while ready_o=1
//   ready_o       out  1         product valid
module mul_iter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_mul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned ProdW = 2 * DATA_W;
  localparam int unsigned CntW  = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    StFree = 2'd0,
    StBusy = 2'd1,
    StEnd  = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_next;

  logic [DATA_W-1:0]  r_mcand;
  logic [DATA_W-1:0]  r_mplier;
  logic [ProdW-1:0]   r_acc;
  logic [CntW-1:0]    r_cnt;
  logic               r_sign;
  logic [ProdW-1:0]   r_result;

  logic               w_go;
  logic               w_zero;
  logic [DATA_W-1:0]  w_abs1;
  logic [DATA_W-1:0]  w_abs2;
  logic [ProdW-1:0]   w_pp;
  logic [ProdW-1:0]   w_acc_next;
  logic [CntW-1:0]    w_cnt_next;
  logic               w_last;

  // Annul beats start when both are asserted in FREE.
  assign w_go   = start_i & ~annul_i;
  assign w_zero = (opdata1_i == '0) | (opdata2_i == '0);

  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign w_abs1 = (signed_mul_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_mul_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Partial product of the multiplicand and the low STEP multiplier bits, placed at cnt.
  assign w_pp       = ProdW'(r_mcand) * ProdW'(r_mplier[STEP-1:0]);
  assign w_acc_next = r_acc + (w_pp << r_cnt);
  assign w_cnt_next = r_cnt + CntW'(STEP);
  assign w_last     = (w_cnt_next == CntW'(DATA_W));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StFree;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFree: begin
        if (w_go) begin
          w_state_next = w_zero ? StEnd : StBusy;
        end
      end
      StBusy: begin
        if (annul_i) begin
          w_state_next = StFree;
        end else if (w_last) begin
          w_state_next = StEnd;
        end
      end
      StEnd: begin
        // No auto-restart: EX must drop start_i before issuing the next operation.
        if (annul_i || !start_i) begin
          w_state_next = StFree;
        end
      end
      default: w_state_next = StFree;
    endcase
  end

  // Outputs: the product is only visible while END holds it.
  always_comb begin
    ready_o  = 1'b0;
    result_o = '0;
    if (r_state == StEnd) begin
      ready_o  = 1'b1;
      result_o = r_result;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StFree: begin
          if (w_go) begin
            if (w_zero) begin
              r_result <= '0;
            end else begin
              r_mcand  <= w_abs1;
              r_mplier <= w_abs2;
              r_sign   <= signed_mul_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_acc    <= '0;
              r_cnt    <= '0;
            end
          end
        end
        StBusy: begin
          if (!annul_i) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> STEP;
            r_cnt    <= w_cnt_next;
            if (w_last) begin
              r_result <= r_sign ? -w_acc_next : w_acc_next;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
module tb_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_mul_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result1;
  logic        ready1;
  logic [63:0] result4;
  logic        ready4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_iter #(.DATA_W(32), .STEP(1)) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .signed_mul_i (signed_mul_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result1),
    .ready_o      (ready1)
  );

  mul_iter #(.DATA_W(32), .STEP(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .signed_mul_i (signed_mul_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result4),
    .ready_o      (ready4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on both instances, measure latencies, check the product, hold
  // start a few cycles to check stability, then drop start and check the return to FREE.
  task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    int edges = 0;
    int lat1 = 0;
    int lat4 = 0;
    int exp_lat1;
    int exp_lat4;
    exp_lat1 = (a == 0 || b == 0) ? 1 : 33;
    exp_lat4 = (a == 0 || b == 0) ? 1 : 9;
    signed_mul_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    while (edges < 45 && (lat1 == 0 || lat4 == 0)) begin
      tick();
      edges++;
      if (edges == 1) begin
        // Operands are latched at start; later changes must not matter.
        opdata1_i    = 32'h1234_5678;
        opdata2_i    = 32'h0000_0009;
        signed_mul_i = ~s;
      end
      if (ready1 && lat1 == 0) lat1 = edges;
      if (ready4 && lat4 == 0) lat4 = edges;
    end
    chk({tag, " lat1"}, 64'(lat1), 64'(exp_lat1));
    chk({tag, " lat4"}, 64'(lat4), 64'(exp_lat4));
    for (int i = 0; i < 3; i++) begin
      chk({tag, " res1"}, result1, exp);
      chk({tag, " res4"}, result4, exp);
      chk({tag, " rdy1 hold"}, 64'(ready1), 64'd1);
      tick();
    end
    start_i = 1'b0;
    tick();
    chk({tag, " rdy1 drop"}, 64'(ready1), 64'd0);
    chk({tag, " rdy4 drop"}, 64'(ready4), 64'd0);
    chk({tag, " res1 drop"}, result1, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [63:0] rexp;
    int          seen;

    rst = 1'b1; signed_mul_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    start_i = 1'b0; annul_i = 1'b0;
    tick();
    tick();
    chk("reset rdy1", 64'(ready1), 64'd0);
    chk("reset res1", result1, 64'd0);
    chk("reset rdy4", 64'(ready4), 64'd0);
    rst = 1'b0;
    tick();

    // T1..T3 directed products
    do_op("T1 u ffff*ffff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_op("T2 s -3*7",      1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("T2 u fffd*7",    1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 64'h0000_0006_FFFF_FFEB);
    do_op("T3 s min*min",   1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_op("T3 s min*1",     1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
    do_op("s -1*-1",        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    do_op("s 7*-2",         1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2);
    do_op("u 12345678*10",  1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);

    // T4 zero shortcut, either operand
    do_op("T4 op2 zero",    1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 64'h0);
    do_op("T4 op1 zero",    1'b1, 32'h0000_0000, 32'h8000_0000, 64'h0);

    // Start and annul together in FREE: annul wins (zero operand would shortcut otherwise)
    opdata1_i = 32'h5; opdata2_i = 32'h0; start_i = 1'b1; annul_i = 1'b1;
    tick();
    tick();
    chk("start+annul free", 64'(ready1), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    tick();

    // T5 annul during BUSY
    signed_mul_i = 1'b0; opdata1_i = 32'hABCD_0123; opdata2_i = 32'h7777_0001; start_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1; start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready1) seen++;
    end
    chk("T5 no ready after annul", 64'(seen), 64'd0);
    chk("T5 res1 after annul", result1, 64'd0);
    do_op("T5 restart 5*6", 1'b0, 32'd5, 32'd6, 64'd30);

    // T6 reset during BUSY with start held through it
    signed_mul_i = 1'b1; opdata1_i = 32'hFFFF_FFF0; opdata2_i = 32'h0000_0100; start_i = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    chk("T6 rdy1 in rst", 64'(ready1), 64'd0);
    chk("T6 res1 in rst", result1, 64'd0);
    tick();
    rst = 1'b0;
    do_op("T6 after rst", 1'b1, 32'hFFFF_FFF0, 32'h0000_0100, 64'hFFFF_FFFF_FFFF_F000);

    // Random products against the language's own multiply
    for (int k = 0; k < 20; k++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      if (rs) rexp = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
      else    rexp = {32'd0, ra} * {32'd0, rb};
      do_op("random", rs, ra, rb, rexp);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
